// File: rtl/branch_resolve_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : branch_pkg
// Brief   : Shared types and constants for the EX-stage branch resolve unit.
// Revision: 1.0
// ============================================================================
package branch_pkg;

   typedef enum logic [2:0] {
      BEQ  = 3'b000,
      BNE  = 3'b001,
      BLT  = 3'b100,
      BGE  = 3'b101,
      BLTU = 3'b110,
      BGEU = 3'b111
   } br_op_e;

   typedef enum logic [0:0] {
      RUN    = 1'b0,
      SQUASH = 1'b1
   } brs_state_e;

   localparam logic [31:0] LINK_OFFSET = 32'd4;
   localparam int          SQ_CNT_W    = 3;

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit_if
// Brief   : ID/EX request, MEM result, redirect and statistics bundle.
// Revision: 1.0
// ============================================================================
interface branch_resolve_unit_if #(
   parameter int CNT_W = 32
);
   logic              valid_i;
   logic              ready_o;
   logic              is_branch_i;
   logic              is_jal_i;
   logic              is_jalr_i;
   logic [2:0]        br_op_i;
   logic [31:0]       pc_i;
   logic [31:0]       imm_i;
   logic [31:0]       rs1_i;
   logic [31:0]       rs2_i;
   logic              flush_i;
   logic              valid_o;
   logic              ready_i;
   logic              taken_o;
   logic [31:0]       target_o;
   logic [31:0]       link_o;
   logic              misalign_o;
   logic              redirect_o;
   logic [31:0]       redirect_pc_o;
   logic [CNT_W-1:0]  br_cnt_o;
   logic [CNT_W-1:0]  taken_cnt_o;

   modport master (
      output valid_i, is_branch_i, is_jal_i, is_jalr_i, br_op_i, pc_i, imm_i,
             rs1_i, rs2_i, flush_i, ready_i,
      input  ready_o, valid_o, taken_o, target_o, link_o, misalign_o,
             redirect_o, redirect_pc_o, br_cnt_o, taken_cnt_o
   );

   modport slave (
      input  valid_i, is_branch_i, is_jal_i, is_jalr_i, br_op_i, pc_i, imm_i,
             rs1_i, rs2_i, flush_i, ready_i,
      output ready_o, valid_o, taken_o, target_o, link_o, misalign_o,
             redirect_o, redirect_pc_o, br_cnt_o, taken_cnt_o
   );
endinterface
`default_nettype wire

// File: rtl/branch_resolve_unit_cond.sv
`default_nettype none
// ============================================================================
// Module  : compare_32bit_s / compare_32bit_u / br_cond_eval
// Brief   : 32-bit comparators and B-type condition evaluation.
// Revision: 1.0
// ============================================================================
module compare_32bit_s (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        eq_o,
   output logic        lt_o
);
   assign eq_o = (a_i == b_i);
   assign lt_o = ($signed(a_i) < $signed(b_i));
endmodule

module compare_32bit_u (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        lt_o
);
   assign lt_o = (a_i < b_i);
endmodule

module br_cond_eval
   import branch_pkg::*;
(
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  logic [2:0]  br_op_i,
   output logic        cond_taken_o
);
   logic w_eq;
   logic w_lt_s;
   logic w_lt_u;

   compare_32bit_s u_cmp_s (
      .a_i  (rs1_i),
      .b_i  (rs2_i),
      .eq_o (w_eq),
      .lt_o (w_lt_s)
   );

   compare_32bit_u u_cmp_u (
      .a_i  (rs1_i),
      .b_i  (rs2_i),
      .lt_o (w_lt_u)
   );

   // funct3 010/011 are reserved encodings and never branch
   always_comb begin
      cond_taken_o = 1'b0;
      case (br_op_i)
         BEQ:     cond_taken_o = w_eq;
         BNE:     cond_taken_o = ~w_eq;
         BLT:     cond_taken_o = w_lt_s;
         BGE:     cond_taken_o = ~w_lt_s;
         BLTU:    cond_taken_o = w_lt_u;
         BGEU:    cond_taken_o = ~w_lt_u;
         default: cond_taken_o = 1'b0;
      endcase
   end
endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : branch_resolve_unit
// Brief   : EX-stage branch/jump resolution, PC redirect, wrong-path squash.
// Revision: 1.0
// ============================================================================
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int SQUASH_DEPTH = 2,
   parameter int CNT_W        = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   branch_resolve_unit_if.slave  bus
);
   localparam logic [SQ_CNT_W-1:0] c_squash_load = SQ_CNT_W'(SQUASH_DEPTH);

   generate
      if (SQUASH_DEPTH < 1 || SQUASH_DEPTH > 7) begin : g_bad_depth
         $error("SQUASH_DEPTH must be within 1..7");
      end
   endgenerate

   brs_state_e           r_state;
   brs_state_e           w_state_nxt;
   logic [SQ_CNT_W-1:0]  r_sq_cnt;
   logic [SQ_CNT_W-1:0]  w_sq_cnt_nxt;

   logic                 r_valid;
   logic                 r_taken;
   logic [31:0]          r_target;
   logic [31:0]          r_link;
   logic                 r_misalign;
   logic                 r_redirect;
   logic [31:0]          r_redirect_pc;
   logic [CNT_W-1:0]     r_br_cnt;
   logic [CNT_W-1:0]     r_taken_cnt;

   logic                 w_ready;
   logic                 w_accept;
   logic                 w_load;
   logic                 w_cond;
   logic                 w_taken;
   logic [31:0]          w_target;
   logic                 w_misalign;
   logic                 w_redirect;

   br_cond_eval u_cond (
      .rs1_i        (bus.rs1_i),
      .rs2_i        (bus.rs2_i),
      .br_op_i      (bus.br_op_i),
      .cond_taken_o (w_cond)
   );

   assign w_ready    = ~r_valid | bus.ready_i;
   assign w_accept   = bus.valid_i & w_ready;
   // Only an accepted instruction on the correct path, not flushed, produces a result
   assign w_load     = w_accept & ~bus.flush_i & (r_state == RUN);

   assign w_taken    = bus.is_jal_i | bus.is_jalr_i | (bus.is_branch_i & w_cond);
   assign w_target   = bus.is_jalr_i ? ((bus.rs1_i + bus.imm_i) & ~32'h1)
                                     : (bus.pc_i + bus.imm_i);
   assign w_misalign = w_taken & (w_target[1:0] != 2'b00);
   assign w_redirect = w_load & w_taken & ~w_misalign;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= RUN;
         r_sq_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_sq_cnt <= w_sq_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sq_cnt_nxt = r_sq_cnt;
      if (bus.flush_i) begin
         w_state_nxt  = RUN;
         w_sq_cnt_nxt = '0;
      end else if (w_accept) begin
         case (r_state)
            SQUASH: begin
               w_sq_cnt_nxt = r_sq_cnt - 1'b1;
               if (r_sq_cnt == SQ_CNT_W'(1)) begin
                  w_state_nxt = RUN;
               end
            end
            default: begin
               if (w_redirect) begin
                  w_state_nxt  = SQUASH;
                  w_sq_cnt_nxt = c_squash_load;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid       <= 1'b0;
         r_taken       <= 1'b0;
         r_target      <= '0;
         r_link        <= '0;
         r_misalign    <= 1'b0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_br_cnt      <= '0;
         r_taken_cnt   <= '0;
      end else begin
         r_redirect <= w_redirect;
         if (bus.flush_i) begin
            r_valid <= 1'b0;
         end else if (w_load) begin
            r_valid    <= 1'b1;
            r_taken    <= w_taken;
            r_target   <= w_target;
            r_link     <= bus.pc_i + LINK_OFFSET;
            r_misalign <= w_misalign;
            if (w_redirect) begin
               r_redirect_pc <= w_target;
            end
            if (bus.is_branch_i) begin
               r_br_cnt <= r_br_cnt + CNT_W'(1);
               if (w_taken) begin
                  r_taken_cnt <= r_taken_cnt + CNT_W'(1);
               end
            end
         end else if (bus.ready_i) begin
            // Also covers a squashed accept: accepting implies the old result drained
            r_valid <= 1'b0;
         end
      end
   end

   assign bus.ready_o       = w_ready;
   assign bus.valid_o       = r_valid;
   assign bus.taken_o       = r_taken;
   assign bus.target_o      = r_target;
   assign bus.link_o        = r_link;
   assign bus.misalign_o    = r_misalign;
   assign bus.redirect_o    = r_redirect;
   assign bus.redirect_pc_o = r_redirect_pc;
   assign bus.br_cnt_o      = r_br_cnt;
   assign bus.taken_cnt_o   = r_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_branch_resolve_unit
// Brief   : Directed and random checks of branch_resolve_unit against a model.
// Revision: 1.0
// ============================================================================
module tb_branch_resolve_unit;
   localparam int SQ    = 2;
   localparam int CNT_W = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   branch_resolve_unit_if #(.CNT_W(CNT_W)) bus ();

   branch_resolve_unit #(.SQUASH_DEPTH(SQ), .CNT_W(CNT_W)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural view of the unit
   logic        m_valid = 0, m_taken = 0, m_mis = 0, m_redir = 0, m_ctrl = 0, m_acc;
   logic [31:0] m_target = 0, m_link = 0, m_rpc = 0, m_br = 0, m_tk = 0;
   int          m_squash = 0;
   logic        r_tk;
   logic [31:0] r_tgt;

   function automatic void resolve(input logic br, jal, jalr, input logic [2:0] op,
                                   input logic [31:0] pc, imm, a, b,
                                   output logic tk, output logic [31:0] tgt);
      logic c;
      case (op)
         3'd0:    c = (a == b);
         3'd1:    c = (a != b);
         3'd4:    c = ($signed(a) <  $signed(b));
         3'd5:    c = ($signed(a) >= $signed(b));
         3'd6:    c = (a <  b);
         3'd7:    c = (a >= b);
         default: c = 1'b0;
      endcase
      tk  = jal || jalr || (br && c);
      tgt = jalr ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_taken = 0; m_mis = 0; m_redir = 0; m_ctrl = 0;
         m_target = 0; m_link = 0; m_rpc = 0; m_br = 0; m_tk = 0; m_squash = 0;
      end else begin
         m_acc   = bus.valid_i && (!m_valid || bus.ready_i);
         m_redir = 0;
         if (bus.flush_i) begin
            m_valid  = 0;
            m_squash = 0;
         end else if (m_acc && m_squash > 0) begin
            m_squash--;
            m_valid = 0;
         end else if (m_acc) begin
            resolve(bus.is_branch_i, bus.is_jal_i, bus.is_jalr_i, bus.br_op_i,
                    bus.pc_i, bus.imm_i, bus.rs1_i, bus.rs2_i, r_tk, r_tgt);
            m_valid  = 1;
            m_taken  = r_tk;
            m_target = r_tgt;
            m_link   = bus.pc_i + 32'd4;
            m_mis    = r_tk && (r_tgt % 4 != 0);
            m_ctrl   = bus.is_branch_i || bus.is_jal_i || bus.is_jalr_i;
            if (bus.is_branch_i) begin
               m_br++;
               if (r_tk) m_tk++;
            end
            if (r_tk && !m_mis) begin
               m_redir  = 1;
               m_rpc    = r_tgt;
               m_squash = SQ;
            end
         end else if (bus.ready_i) begin
            m_valid = 0;
         end
      end
   end

   // Compare process
   always @(negedge clk) begin
      if (rst_n) chk("ready_o", bus.ready_o, !m_valid || bus.ready_i);
      chk("valid_o", bus.valid_o, m_valid);
      chk("redirect_o", bus.redirect_o, m_redir);
      chk("redirect_pc_o", bus.redirect_pc_o, m_rpc);
      chk("br_cnt_o", bus.br_cnt_o, m_br);
      chk("taken_cnt_o", bus.taken_cnt_o, m_tk);
      if (m_valid) begin
         chk("taken_o", bus.taken_o, m_taken);
         chk("link_o", bus.link_o, m_link);
         chk("misalign_o", bus.misalign_o, m_mis);
         if (m_ctrl) chk("target_o", bus.target_o, m_target);
      end
   end

   // kind: 0 none, 1 branch, 2 jal, 3 jalr; holds one cycle then drops valid_i/flush_i
   task automatic issue(input int kind, input logic [2:0] op, input logic [31:0] pc, imm, a, b);
      bus.valid_i     = 1'b1;
      bus.is_branch_i = (kind == 1);
      bus.is_jal_i    = (kind == 2);
      bus.is_jalr_i   = (kind == 3);
      bus.br_op_i     = op;
      bus.pc_i        = pc;
      bus.imm_i       = imm;
      bus.rs1_i       = a;
      bus.rs2_i       = b;
      @(posedge clk); #1;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
   endtask

   initial begin
      bus.valid_i = 0; bus.is_branch_i = 0; bus.is_jal_i = 0; bus.is_jalr_i = 0;
      bus.br_op_i = 0; bus.pc_i = 0; bus.imm_i = 0; bus.rs1_i = 0; bus.rs2_i = 0;
      bus.flush_i = 0; bus.ready_i = 1;
      repeat (3) @(negedge clk);
      chk("reset valid_o", bus.valid_o, 0);
      chk("reset redirect_pc_o", bus.redirect_pc_o, 0);
      chk("reset br_cnt_o", bus.br_cnt_o, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // BLTU -1 < 1 unsigned is false
      issue(1, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
      chk("bltu valid", bus.valid_o, 1);
      chk("bltu taken", bus.taken_o, 0);
      chk("bltu redirect", bus.redirect_o, 0);
      chk("bltu br_cnt", bus.br_cnt_o, 1);
      chk("bltu taken_cnt", bus.taken_cnt_o, 0);

      // BLT -1 < 1 signed is true; next two accepts squashed, third passes
      issue(1, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'h1);
      chk("blt redirect", bus.redirect_o, 1);
      chk("blt redirect_pc", bus.redirect_pc_o, 32'h120);
      chk("blt taken", bus.taken_o, 1);
      issue(1, 3'b000, 32'h104, 32'h40, 32'h5, 32'h5);
      chk("squash1 valid", bus.valid_o, 0);
      chk("squash1 redirect", bus.redirect_o, 0);
      issue(1, 3'b000, 32'h108, 32'h40, 32'h5, 32'h5);
      chk("squash2 valid", bus.valid_o, 0);
      issue(0, 3'b000, 32'h120, 32'h0, 32'h0, 32'h0);
      chk("post squash valid", bus.valid_o, 1);
      chk("post squash br_cnt", bus.br_cnt_o, 2);
      chk("post squash taken_cnt", bus.taken_cnt_o, 1);

      // JALR to misaligned target
      issue(3, 3'b000, 32'h200, 32'h4, 32'h1003, 32'h0);
      chk("jalr target", bus.target_o, 32'h1006);
      chk("jalr misalign", bus.misalign_o, 1);
      chk("jalr taken", bus.taken_o, 1);
      chk("jalr redirect", bus.redirect_o, 0);
      chk("jalr link", bus.link_o, 32'h204);

      // BEQ taken under backpressure
      @(posedge clk); #1;
      bus.ready_i = 1'b0;
      issue(1, 3'b000, 32'h300, 32'h8, 32'h7, 32'h7);
      chk("beq redirect", bus.redirect_o, 1);
      chk("beq target", bus.target_o, 32'h308);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("hold ready_o", bus.ready_o, 0);
         chk("hold valid_o", bus.valid_o, 1);
         chk("hold redirect_o", bus.redirect_o, 0);
         chk("hold target_o", bus.target_o, 32'h308);
      end
      bus.ready_i = 1'b1;

      // Squash counter 2 -> 1, then flush the next accept
      issue(0, 3'b000, 32'h304, 32'h0, 32'h0, 32'h0);
      chk("sq drop valid", bus.valid_o, 0);
      bus.flush_i = 1'b1;
      issue(1, 3'b000, 32'h500, 32'h4, 32'h1, 32'h1);
      chk("flush valid", bus.valid_o, 0);
      chk("flush br_cnt", bus.br_cnt_o, 3);
      issue(2, 3'b000, 32'h600, 32'h8, 32'h0, 32'h0);
      chk("after flush valid", bus.valid_o, 1);
      chk("after flush redirect", bus.redirect_o, 1);

      // Asynchronous reset while squashing
      #2 rst_n = 1'b0;
      #1;
      chk("async rst valid", bus.valid_o, 0);
      chk("async rst redirect", bus.redirect_o, 0);
      chk("async rst redirect_pc", bus.redirect_pc_o, 0);
      chk("async rst br_cnt", bus.br_cnt_o, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1, 3'b001, 32'h400, 32'h10, 32'h5, 32'h6);
      chk("bne taken", bus.taken_o, 1);
      chk("bne redirect", bus.redirect_o, 1);
      chk("bne redirect_pc", bus.redirect_pc_o, 32'h410);
      chk("bne br_cnt", bus.br_cnt_o, 1);
      chk("bne taken_cnt", bus.taken_cnt_o, 1);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         int k;
         k = $urandom_range(0, 3);
         bus.valid_i     = ($urandom_range(0, 99) < 70);
         bus.is_branch_i = (k == 1);
         bus.is_jal_i    = (k == 2);
         bus.is_jalr_i   = (k == 3);
         bus.br_op_i     = 3'($urandom_range(0, 7));
         bus.pc_i        = $urandom & 32'hFFFF_FFFC;
         bus.imm_i       = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 255)) - 128);
         bus.rs1_i       = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 3)) - 32'd1;
         bus.rs2_i       = ($urandom_range(0, 3) == 0) ? bus.rs1_i : $urandom;
         bus.ready_i     = ($urandom_range(0, 99) < 70);
         bus.flush_i     = ($urandom_range(0, 99) < 5);
         @(posedge clk); #1;
      end
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
